// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index counter needs at least one bit even when a single chunk covers the word.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/csa_resolver_if.sv
// Operand and result handshakes of the carry-save resolver.
interface csa_resolver_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_cy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_result;

    modport slave (
        input  in_valid, in_sum, in_cy, out_ready,
        output in_ready, out_valid, out_result
    );

    modport master (
        output in_valid, in_sum, in_cy, out_ready,
        input  in_ready, out_valid, out_result
    );
endinterface

// File: rtl/csa_chunk_add.sv
// Combinational CHUNK-bit ripple adder built from full-adder bit cells.
module csa_chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
endmodule

// File: rtl/csa_resolver.sv
// Multi-cycle carry-propagate adder collapsing a carry-save pair to binary, CHUNK bits per cycle.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    csa_resolver_if.slave      bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    csa_state_e       state;
    logic [WIDTH-1:0] op_sum;
    logic [WIDTH-1:0] op_cy;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [WIDTH:0]   result;
    logic             rdy;
    logic             vld;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] s_c;
    logic             c_out;
    logic             accept;

    assign accept = (state == IDLE) && rdy && bus.in_valid;

    assign a_c = op_sum[idx*CHUNK +: CHUNK];
    assign b_c = op_cy[idx*CHUNK +: CHUNK];

    csa_chunk_add #(
        .CHUNK (CHUNK)
    ) u_add (
        .a    (a_c),
        .b    (b_c),
        .cin  (carry),
        .sum  (s_c),
        .cout (c_out)
    );

    // Operands are pure data: captured on acceptance, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_sum <= bus.in_sum;
            op_cy  <= bus.in_cy;
        end
    end

    // in_ready is a flop cleared by reset so it stays low while rst_n is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rdy    <= 1'b0;
            vld    <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rdy <= 1'b1;
                    if (accept) begin
                        rdy   <= 1'b0;
                        idx   <= '0;
                        carry <= 1'b0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    result[idx*CHUNK +: CHUNK] <= s_c;
                    carry <= c_out;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        result[WIDTH] <= c_out;
                        vld   <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        vld   <= 1'b0;
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = rdy;
    assign bus.out_valid  = vld;
    assign bus.out_result = result;
endmodule

// File: doc/csa_resolver.md
# csa_resolver

Converts a carry-save (redundant) operand pair, as produced by a row of 3:2 carry-save cells, into one binary result. It is a multi-cycle carry-propagate adder that processes CHUNK bits per cycle, with valid/ready handshakes on input and output. It sits at the end of a carry-save accumulation tree, where the final redundant sum/carry must be collapsed to binary.

## Interface
- WIDTH, 32, operand width in bits
- CHUNK, 8, bits resolved per cycle; must divide WIDTH (CHUNK = WIDTH legal)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  block can accept an operand pair
- in_sum  in  WIDTH  carry-save sum vector
- in_cy  in  WIDTH  carry-save carry vector, already aligned by the caller (value = in_sum + in_cy)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH+1  binary in_sum + in_cy, bit WIDTH = final carry-out

## Operation
- NCHUNK = WIDTH/CHUNK; chunk index counter width clog2(NCHUNK), minimum 1.
- FSM states: IDLE, ADD, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready: register in_sum, in_cy; chunk index = 0; carry register = 0; go to ADD.
- ADD: each cycle add chunk idx of both registered operands plus carry register; write CHUNK-bit sum into out_result[idx*CHUNK +: CHUNK]; carry register = chunk carry-out; idx++. On idx = NCHUNK-1: out_result[WIDTH] = chunk carry-out, go to DONE.
- DONE: out_valid = 1; out_result held stable. On out_valid && out_ready go to IDLE.
- in_ready = 0 in ADD and DONE; in_valid ignored there. Input buses may change freely after acceptance.
- Arithmetic: unsigned, modulo nothing, full WIDTH+1-bit result; no overflow possible.
- Reset (any state, including mid-ADD or DONE): state = IDLE, out_valid = 0, out_result = 0, carry = 0, idx = 0; in-flight operation discarded, no output produced. in_ready forced 0 while rst_n low, 1 from first cycle after release.

## Timing
- Acceptance edge = E. ADD occupies edges E+1 .. E+NCHUNK; out_valid high after edge E+NCHUNK (latency NCHUNK cycles; 4 for defaults, 1 for CHUNK = WIDTH).
- Result handshake at edge F returns to IDLE; in_ready high after F, so the next acceptance is at F+1 earliest. Max throughput: one result per NCHUNK+2 cycles.
- out_ready high before out_valid rises does not shorten latency; DONE always lasts at least one cycle.
- No combinational path from in_* to out_* or from out_ready to in_ready.

## Structure
- Package csa_pkg: state enum (IDLE, ADD, DONE), function/localparam for NCHUNK and index width.
- Sub-module csa_chunk_add: combinational CHUNK-bit ripple adder (a, b, cin -> sum, cout), built from full-adder bit cells; one instance, chunk selected by index mux.
- Top holds FSM, operand registers, carry register, index counter, result register.

## Test plan
- Reset: hold rst_n low mid-stimulus -> out_valid 0, out_result 0, in_ready 0; after release in_ready 1, state IDLE.
- in_sum = 0x0000_00FF, in_cy = 0x0000_0001 -> out_valid exactly 4 cycles after acceptance, out_result = 0x0_0000_0100.
- in_sum = 0xFFFF_FFFF, in_cy = 0x0000_0001 -> carry ripples through all chunks, out_result = 0x1_0000_0000; also 0xFFFF_FFFF + 0xFFFF_FFFF -> 0x1_FFFF_FFFE.
- Backpressure: out_ready low 5 cycles after out_valid -> out_result stable, in_ready 0, new in_valid ignored; out_ready high -> IDLE, next pair accepted one cycle later.
- Reset asserted during ADD (after 2 chunks) -> no out_valid ever for that operation; next accepted pair produces correct result.
- 1000 random pairs with random in_valid/out_ready, for (32,8) and (32,32) and (16,4) configs -> every out_result equals reference in_sum + in_cy, in order, none dropped or duplicated.
